// File: rtl/gpu_cmd_queue.sv
// CPU-to-GPU command queue: buffers validated command/parameter pairs and
// streams them on cpuline in fixed 3-cycle frames, with 2-cycle zero idle slots.
//
// Write handshake: a pair transfers on a rising edge when wr_en=1 and wr_ready=1.
// wr_ready depends on count only. A write with wr_ready=0 is dropped and sets
// err_ovf. A write with an illegal code or an out-of-range parameter is dropped
// and sets err_ill.
module gpu_cmd_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_cmd,
  input  logic [15:0] wr_param,
  input  logic        err_clr,
  output logic        wr_ready,
  output logic [15:0] cpuline,
  output logic [6:0]  count,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_ill,
  output logic [2:0]  dbg_state_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE0 = 3'd0,
    S_IDLE1 = 3'd1,
    S_CMD   = 3'd2,
    S_PARAM = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    count_q, count_d;
  logic [15:0]   cpuline_q, cpuline_d;
  logic          busy_q, busy_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_ill_q, err_ill_d;

  logic [15:0] cmd_mem   [DEPTH];
  logic [15:0] param_mem [DEPTH];

  logic cmd_known;
  logic range_bad;
  logic legal;
  logic ovf_evt;
  logic ill_evt;
  logic accept;
  logic pop;
  logic boundary;

  assign wr_ready = (count_q != 7'(DEPTH));

  always_comb begin
    cmd_known = (wr_cmd >= 16'h00C0) && (wr_cmd <= 16'h00C6);
    range_bad = ((wr_cmd == 16'h00C3) && (wr_param > 16'd24)) ||
                ((wr_cmd == 16'h00C4) && (wr_param > 16'd39));
    legal     = cmd_known && !range_bad;
    ovf_evt   = wr_en && !wr_ready;
    ill_evt   = wr_en && !legal;
    accept    = wr_en && wr_ready && legal;
    pop       = (state_q == S_PARAM);
    boundary  = (state_q == S_IDLE1) || (state_q == S_GAP);
  end

  // Slot sequencer: boundaries look at the count before this edge's write lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE0: state_d = S_IDLE1;
      S_CMD:   state_d = S_PARAM;
      S_PARAM: state_d = S_GAP;
      S_IDLE1,
      S_GAP:   state_d = (count_q != 7'd0) ? S_CMD : S_IDLE0;
      default: state_d = S_GAP;
    endcase
    if (!boundary && (state_q != S_IDLE0) && (state_q != S_CMD) &&
        (state_q != S_PARAM)) begin
      state_d = S_GAP;
    end
  end

  // The head entry is only retired after its parameter has gone out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    cpuline_d = 16'h0000;
    case (state_d)
      S_CMD:   cpuline_d = cmd_mem[rd_ptr_q];
      S_PARAM: cpuline_d = param_mem[rd_ptr_q];
      default: cpuline_d = 16'h0000;
    endcase
    busy_d = (count_d != 7'd0) ||
             ((state_d != S_IDLE0) && (state_d != S_IDLE1));
  end

  // A new error in the same cycle as err_clr wins.
  always_comb begin
    err_ovf_d = err_ovf_q;
    err_ill_d = err_ill_q;
    if (err_clr) begin
      err_ovf_d = 1'b0;
      err_ill_d = 1'b0;
    end
    if (ovf_evt) begin
      err_ovf_d = 1'b1;
    end
    if (ill_evt) begin
      err_ill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_GAP;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 7'd0;
      cpuline_q <= 16'h0000;
      busy_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cpuline_q <= cpuline_d;
      busy_q    <= busy_d;
      err_ovf_q <= err_ovf_d;
      err_ill_q <= err_ill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_mem[wr_ptr_q]   <= wr_cmd;
      param_mem[wr_ptr_q] <= wr_param;
    end
  end

  assign cpuline     = cpuline_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign err_ovf     = err_ovf_q;
  assign err_ill     = err_ill_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Bench for gpu_cmd_queue: directed scenarios plus random traffic, every cycle
// checked against a slot-level model built on a queue of pending pairs.
module tb_gpu_cmd_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_cmd;
  logic [15:0] wr_param;
  logic        err_clr;
  logic        wr_ready;
  logic [15:0] cpuline;
  logic [6:0]  count;
  logic        busy;
  logic        err_ovf;
  logic        err_ill;
  logic [2:0]  dbg_state;

  gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_cmd      (wr_cmd),
    .wr_param    (wr_param),
    .err_clr     (err_clr),
    .wr_ready    (wr_ready),
    .cpuline     (cpuline),
    .count       (count),
    .busy        (busy),
    .err_ovf     (err_ovf),
    .err_ill     (err_ill),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];   // pending {cmd, param}, head at index 0
  int          m_kind;     // 0 = idle slot (2 cycles), 1 = command slot (3 cycles)
  int          m_pos;      // cycle index inside the current slot
  logic [15:0] m_line;
  logic        m_ovf;
  logic        m_ill;
  logic        m_busy;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [15:0] c, input logic [15:0] p);
    return (c >= 16'h00C0) && (c <= 16'h00C6) &&
           !((c == 16'h00C3) && (p > 16'd24)) &&
           !((c == 16'h00C4) && (p > 16'd39));
  endfunction

  // After reset the sequencer sits at the last cycle of a command slot.
  task automatic model_reset();
    exp_q.delete();
    m_kind = 1;
    m_pos  = 2;
    m_line = 16'h0000;
    m_ovf  = 1'b0;
    m_ill  = 1'b0;
    m_busy = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int  sz;
    logic rdy, acc, do_pop, slot_end;
    if (!reset) begin
      model_reset();
      return;
    end
    sz       = exp_q.size();
    rdy      = (sz != DEPTH);
    acc      = wr_en && rdy && legal(wr_cmd, wr_param);
    do_pop   = (m_kind == 1) && (m_pos == 1);
    slot_end = (m_kind == 0) ? (m_pos == 1) : (m_pos == 2);
    if (slot_end) begin
      m_kind = (sz != 0) ? 1 : 0;
      m_pos  = 0;
    end else begin
      m_pos++;
    end
    if (m_kind == 1 && m_pos == 0)      m_line = exp_q[0][31:16];
    else if (m_kind == 1 && m_pos == 1) m_line = exp_q[0][15:0];
    else                                m_line = 16'h0000;
    if (do_pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({wr_cmd, wr_param});
    if (err_clr) begin
      m_ovf = 1'b0;
      m_ill = 1'b0;
    end
    if (wr_en && !rdy) m_ovf = 1'b1;
    if (wr_en && !legal(wr_cmd, wr_param)) m_ill = 1'b1;
    m_busy = (exp_q.size() != 0) || (m_kind == 1);
  endtask

  task automatic check_all();
    check_eq("cpuline",  {16'h0, cpuline},  {16'h0, m_line});
    check_eq("count",    {25'h0, count},    exp_q.size());
    check_eq("wr_ready", {31'h0, wr_ready}, {31'h0, (exp_q.size() != DEPTH)});
    check_eq("busy",     {31'h0, busy},     {31'h0, m_busy});
    check_eq("err_ovf",  {31'h0, err_ovf},  {31'h0, m_ovf});
    check_eq("err_ill",  {31'h0, err_ill},  {31'h0, m_ill});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic [15:0] c, input logic [15:0] p,
                      input logic clr);
    wr_en    = en;
    wr_cmd   = c;
    wr_param = p;
    err_clr  = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Reset asserted away from the clock edge; outputs must drop at once.
  task automatic async_reset(input int hold_cycles);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_cpuline",  {16'h0, cpuline},  32'h0);
    check_eq("rst_count",    {25'h0, count},    32'h0);
    check_eq("rst_busy",     {31'h0, busy},     32'h0);
    check_eq("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    check_eq("rst_err_ovf",  {31'h0, err_ovf},  32'h0);
    check_eq("rst_err_ill",  {31'h0, err_ill},  32'h0);
    for (int i = 0; i < hold_cycles; i++) step(1'b1, 16'h00C2, 16'h0BAD, 1'b0);
    reset = 1'b1;
  endtask

  function automatic logic [15:0] legal_param(input logic [15:0] c, input int seed);
    if (c == 16'h00C3) return 16'(seed % 25);
    if (c == 16'h00C4) return 16'(seed % 40);
    return 16'(seed);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int found;
    logic [15:0] c, p;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_cmd   = 16'h0;
    wr_param = 16'h0;
    err_clr  = 1'b0;
    model_reset();
    #2;
    async_reset(2);

    // Single pair into an idle queue.
    idle(3);
    step(1'b1, 16'h00C1, 16'h0041, 1'b0);
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      idle(1);
      if (cpuline == 16'h00C1) found = 1;
    end
    check_eq("c1_seen", found, 1);
    idle(1);
    check_eq("c1_param", {16'h0, cpuline}, 32'h0041);
    idle(1);
    check_eq("c1_gap", {16'h0, cpuline}, 32'h0);
    check_eq("c1_count", {25'h0, count}, 32'h0);
    idle(6);

    // Nine writes back to back from an idle emitter.
    async_reset(1);
    idle(1);
    for (int i = 0; i < 9; i++) step(1'b1, 16'h00C0 + 16'(i % 7), 16'(16'h100 + i), 1'b0);
    idle(40);

    // Illegal code and range checks.
    step(1'b1, 16'h00C7, 16'h0001, 1'b0);
    step(1'b1, 16'h00C3, 16'd25, 1'b0);
    step(1'b1, 16'h00C4, 16'd39, 1'b0);
    check_eq("ill_flag", {31'h0, err_ill}, 32'h1);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'h00C3, 16'd24, 1'b0);
    idle(15);

    // Continuous writes past full: order and pointer wrap over many entries.
    step(1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      c = 16'h00C0 + 16'(i % 7);
      step(1'b1, c, legal_param(c, i), 1'b0);
    end
    check_eq("fill_ovf", {31'h0, err_ovf}, 32'h1);

    // err_clr loses against a simultaneous overflow.
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (exp_q.size() == DEPTH) found = 1;
      else step(1'b1, 16'h00C5, 16'h5555, 1'b0);
    end
    check_eq("full_reached", found, 1);
    step(1'b1, 16'h00C6, 16'h6666, 1'b1);
    check_eq("clr_prio_ovf", {31'h0, err_ovf}, 32'h1);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    check_eq("clr_alone_ovf", {31'h0, err_ovf}, 32'h0);
    idle(40);

    // Reset during the parameter cycle of a C6.
    step(1'b1, 16'h00C6, 16'h1234, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      idle(1);
      if (m_kind == 1 && m_pos == 1) found = 1;
    end
    check_eq("c6_param_reached", found, 1);
    check_eq("c6_param_line", {16'h0, cpuline}, 32'h1234);
    async_reset(2);
    step(1'b1, 16'h00C5, 16'h0055, 1'b0);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset($urandom_range(0, 2));
      end
      c = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                      : 16'h00C0 + 16'($urandom_range(0, 6));
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 45));
      step($urandom_range(0, 99) < 55, c, p, $urandom_range(0, 19) == 0);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
